sprite_table_responder: RTL and testbench
=========================================

// Module: sprite_table_responder
// PURPOSE
//   Write-side responder for the stack machine's memory-store port (write/wr_addr/wr_data).
//   Decodes each store into the sprite attribute table or a control register.
//   Buffers stores in a small FIFO. Defers sprite-table updates to vertical blank so the
//   renderer never sees a half-updated sprite.
//   Sits between the stack machine and the sprite renderer, in the same clock domain.
// PARAMETERS
//   FIFO_DEPTH   8    store-buffer entries; power of two, >= 2
//   NUM_SPRITES  16   sprite table entries; 4 byte fields each
// PORTS
//   clock          in   1   system clock
//   reset          in   1   asynchronous, active-high
//   write          in   1   single-cycle store strobe from stack machine
//   wr_addr        in   16  store address
//   wr_data        in   16  store data; only [7:0] is used
//   vblank         in   1   high while the renderer is not reading the table
//   clear_overflow in   1   clears the sticky fifo_overflow flag
//   rd_index       in   4   sprite index requested by the renderer
//   rd_attr        out  32  {x,y,tile,attr} of sprite rd_index, 1-cycle latency
//   ctrl_enable    out  1   sprite layer enable (ctrl reg bit 0)
//   bg_color       out  8   background colour register
//   fifo_overflow  out  1   sticky: a store was dropped because the FIFO was full
//   busy           out  1   FIFO not empty
// BEHAVIOUR
//   Reset (async): FIFO flushed; FSM to S_IDLE; all table fields 0.
//     rd_attr, ctrl_enable, bg_color and fifo_overflow all 0.
//     Reset mid-drain discards every pending store.
//   Address decode:
//     wr_addr[15:8] != 0: store ignored, not enqueued.
//     0x00-0x3F: table; sprite = addr[5:2]; field = addr[1:0] (0 x, 1 y, 2 tile, 3 attr).
//     0x40: ctrl_enable <= data[0].  0x41: bg_color <= data[7:0].
//     0x42-0xFF: ignored, not enqueued.
//   Enqueue:
//     Each decoded store pushes {addr[7:0], data[7:0]} at the edge where write is sampled.
//     The stack machine cannot stall, so there is no backpressure.
//     Full FIFO with no pop that cycle: store dropped; fifo_overflow <= 1.
//     Full FIFO with a pop the same cycle: push accepted.
//     fifo_overflow stays set until clear_overflow. A set and a clear in the same cycle: set wins.
//   Drain FSM, head entries retired strictly in order:
//     S_IDLE:  FIFO empty. -> S_DRAIN when not empty.
//     S_DRAIN: head is a ctrl store, or a table store with vblank=1 -> commit and pop (1 per cycle).
//              Head is a table store with vblank=0 -> S_HOLD without popping.
//              FIFO becomes empty -> S_IDLE.
//     S_HOLD:  head is held. -> S_DRAIN on the cycle vblank=1.
//              Ctrl stores queued behind the held entry also wait (ordering is preserved).
//   Latency: strobe sampled at edge N; commit at edge N+1 at the earliest. Register outputs and
//     the table reflect the store from edge N+1.
//   Read port: rd_attr is registered from the table and index sampled at each edge.
//     A read and a commit to the same sprite in the same cycle return the old value.
//   Back-to-back strobes on consecutive cycles are all accepted while the FIFO is not full.
// STRUCTURE
//   Shared package sprite_pkg:
//     address constants ADDR_CTRL=8'h40, ADDR_BG=8'h41, TABLE_LIMIT=8'h40;
//     field offsets FLD_X..FLD_ATTR; FSM state enum.
//   Sub-module store_fifo: synchronous FIFO, 16-bit entries, push/pop/full/empty,
//     simultaneous push+pop when full.
//   Top level: decode, FSM, table registers, read register.
// TESTING
//   1. Store 0x05->0x41, vblank=0: bg_color=0x05 one edge after the strobe. busy low again afterwards.
//   2. Store 0x22->0x08 (sprite 2 x), vblank=0 for 10 cycles:
//      busy=1 and rd_index=2 gives rd_attr=0 throughout; vblank=1 -> rd_attr[31:24]=0x22.
//   3. vblank=0; 9 table stores back-to-back with FIFO_DEPTH=8:
//      9th dropped and fifo_overflow=1; raise vblank -> 8 commits; clear_overflow -> 0.
//   4. Ordering: table store, then 0x01->0x40, with vblank=0:
//      ctrl_enable stays 0 until vblank=1; then the table entry commits first, ctrl_enable=1 next cycle.
//   5. Stores to 0x0100 and 0x7F: not enqueued, busy stays 0, no register or table change.
//   6. Assert reset with 4 stores pending: all outputs 0 asynchronously;
//      after release busy=0 and the table stays 0 through vblank.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite table write responder: store address map,
// attribute field offsets, store-buffer entry layout and drain FSM states.
package sprite_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h40;
    localparam logic [7:0] ADDR_BG     = 8'h41;
    localparam logic [7:0] TABLE_LIMIT = 8'h40;

    localparam logic [1:0] FLD_X    = 2'd0;
    localparam logic [1:0] FLD_Y    = 2'd1;
    localparam logic [1:0] FLD_TILE = 2'd2;
    localparam logic [1:0] FLD_ATTR = 2'd3;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } store_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/store_fifo.sv
// Synchronous store buffer. A push into a full FIFO is accepted only when a pop
// retires the head in the same cycle.
module store_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sprite_table_responder.sv
// Decodes stack-machine stores into the sprite attribute table and control
// registers; table updates are held in order until vertical blank.
module sprite_table_responder
    import sprite_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned NUM_SPRITES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        vblank,
    input  logic        clear_overflow,
    input  logic [3:0]  rd_index,
    output logic [31:0] rd_attr,
    output logic        ctrl_enable,
    output logic [7:0]  bg_color,
    output logic        fifo_overflow,
    output logic        busy
);

    logic [7:0] table_q [NUM_SPRITES][4];
    state_t     state;
    state_t     state_next;
    store_t     head;
    store_t     push_entry;
    logic       decoded;
    logic       full;
    logic       empty;
    logic       pop;
    logic       head_blocked;
    logic       unused_data;

    assign unused_data = ^{wr_data[15:8], 1'b0};

    assign decoded    = write && (wr_addr[15:8] == 8'h00) && (wr_addr[7:0] <= ADDR_BG);
    assign push_entry = '{addr: wr_addr[7:0], data: wr_data[7:0]};

    store_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (decoded),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign busy         = !empty;
    assign head_blocked = (head.addr < TABLE_LIMIT) && !vblank;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Idle also commits so a store can retire on the edge right after it was queued.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE, S_DRAIN: begin
                if (empty) begin
                    state_next = S_IDLE;
                end else if (head_blocked) begin
                    state_next = S_HOLD;
                end else begin
                    pop        = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (vblank) begin
                    pop        = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            bg_color    <= '0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    table_q[i][j] <= '0;
                end
            end
        end else if (pop) begin
            if (head.addr == ADDR_CTRL)    ctrl_enable <= head.data[0];
            else if (head.addr == ADDR_BG) bg_color    <= head.data;
            else table_q[head.addr[5:2]][head.addr[1:0]] <= head.data;
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                        fifo_overflow <= 1'b0;
        else if (decoded && full && !pop) fifo_overflow <= 1'b1;
        else if (clear_overflow)          fifo_overflow <= 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_attr <= '0;
        else       rd_attr <= {table_q[rd_index][FLD_X], table_q[rd_index][FLD_Y],
                               table_q[rd_index][FLD_TILE], table_q[rd_index][FLD_ATTR]};
    end

endmodule

// File: tb/tb_sprite_table_responder.sv
// Directed bench for sprite_table_responder: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that acts on them.
module tb_sprite_table_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        vblank = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [3:0]  rd_index = '0;
    logic [31:0] rd_attr;
    logic        ctrl_enable;
    logic [7:0]  bg_color;
    logic        fifo_overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sprite_table_responder #(
        .FIFO_DEPTH  (8),
        .NUM_SPRITES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .write          (write),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .vblank         (vblank),
        .clear_overflow (clear_overflow),
        .rd_index       (rd_index),
        .rd_attr        (rd_attr),
        .ctrl_enable    (ctrl_enable),
        .bg_color       (bg_color),
        .fifo_overflow  (fifo_overflow),
        .busy           (busy)
    );

    // One-cycle strobe; returns on the falling edge after the sampling edge.
    task automatic store(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        write   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        write   = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL reset_rd_attr got=%h exp=%h", rd_attr, 32'h0); end
        checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", ctrl_enable); end
        checks++; if (bg_color !== 8'h00) begin errors++; $display("FAIL reset_bg got=%h exp=00", bg_color); end
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", fifo_overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clock);
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_ctrl_store();
        vblank = 1'b0;
        store(16'h0041, 16'hFF05);
        checks++; if (bg_color !== 8'h00) begin errors++; $display("FAIL bg_before_commit got=%h exp=00", bg_color); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bg_busy_queued got=%b exp=1", busy); end
        cycles(1);
        checks++; if (bg_color !== 8'h05) begin errors++; $display("FAIL bg_commit got=%h exp=05", bg_color); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bg_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_vblank_hold();
        vblank   = 1'b0;
        rd_index = 4'd2;
        store(16'h0008, 16'h0022);
        for (int i = 0; i < 10; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy cyc=%0d got=%b exp=1", i, busy); end
            checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL hold_rd_attr cyc=%0d got=%h exp=0", i, rd_attr); end
            cycles(1);
        end
        vblank = 1'b1;
        cycles(2);
        checks++; if (rd_attr !== 32'h2200_0000) begin errors++; $display("FAIL vblank_commit got=%h exp=%h", rd_attr, 32'h2200_0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vblank_busy got=%b exp=0", busy); end
        vblank = 1'b0;
    endtask

    task automatic test_overflow();
        vblank = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i == 8) begin
                checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_9th got=%b exp=0", fifo_overflow); end
            end
            write   = 1'b1;
            wr_addr = 16'h0010 + 16'(i);
            wr_data = 16'h0030 + 16'(i);
        end
        @(negedge clock);
        write = 1'b0;
        checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", fifo_overflow); end
        vblank = 1'b1;
        cycles(7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy_7 got=%b exp=1", busy); end
        cycles(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_8 got=%b exp=0", busy); end
        checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", fifo_overflow); end
        rd_index = 4'd4;
        cycles(1);
        checks++; if (rd_attr !== 32'h3031_3233) begin errors++; $display("FAIL ovf_sprite4 got=%h exp=30313233", rd_attr); end
        rd_index = 4'd5;
        cycles(1);
        checks++; if (rd_attr !== 32'h3435_3637) begin errors++; $display("FAIL ovf_sprite5 got=%h exp=34353637", rd_attr); end
        rd_index = 4'd6;
        cycles(1);
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL ovf_dropped got=%h exp=0", rd_attr); end
        clear_overflow = 1'b1;
        cycles(1);
        clear_overflow = 1'b0;
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", fifo_overflow); end
        vblank = 1'b0;
    endtask

    task automatic test_ordering();
        vblank   = 1'b0;
        rd_index = 4'd3;
        store(16'h000C, 16'h0044);
        store(16'h0040, 16'h0001);
        cycles(5);
        checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL order_ctrl_held got=%b exp=0", ctrl_enable); end
        vblank = 1'b1;
        cycles(1);
        checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL order_ctrl_first got=%b exp=0", ctrl_enable); end
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL order_read_old got=%h exp=0", rd_attr); end
        cycles(1);
        checks++; if (ctrl_enable !== 1'b1) begin errors++; $display("FAIL order_ctrl_second got=%b exp=1", ctrl_enable); end
        checks++; if (rd_attr !== 32'h4400_0000) begin errors++; $display("FAIL order_table got=%h exp=44000000", rd_attr); end
        vblank = 1'b0;
    endtask

    task automatic test_ignored();
        vblank   = 1'b1;
        rd_index = 4'd0;
        store(16'h0100, 16'h00AA);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_high_busy got=%b exp=0", busy); end
        store(16'h007F, 16'h00BB);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_7f_busy got=%b exp=0", busy); end
        cycles(2);
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL ign_sprite0 got=%h exp=0", rd_attr); end
        checks++; if (bg_color !== 8'h05) begin errors++; $display("FAIL ign_bg got=%h exp=05", bg_color); end
        checks++; if (ctrl_enable !== 1'b1) begin errors++; $display("FAIL ign_ctrl got=%b exp=1", ctrl_enable); end
        vblank = 1'b0;
    endtask

    task automatic test_reset_pending();
        vblank   = 1'b0;
        rd_index = 4'd3;
        for (int i = 0; i < 4; i++) store(16'h001C + 16'(i), 16'h0011 + 16'(i));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pending_busy got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL rst_async_rd_attr got=%h exp=0", rd_attr); end
        checks++; if (ctrl_enable !== 1'b0) begin errors++; $display("FAIL rst_async_ctrl got=%b exp=0", ctrl_enable); end
        checks++; if (bg_color !== 8'h00) begin errors++; $display("FAIL rst_async_bg got=%h exp=00", bg_color); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        @(negedge clock);
        reset  = 1'b0;
        vblank = 1'b1;
        rd_index = 4'd7;
        cycles(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got=%b exp=0", busy); end
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL rst_sprite7 got=%h exp=0", rd_attr); end
        rd_index = 4'd3;
        cycles(1);
        checks++; if (rd_attr !== 32'h0) begin errors++; $display("FAIL rst_sprite3 got=%h exp=0", rd_attr); end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ctrl_store();
        test_vblank_hold();
        test_overflow();
        test_ordering();
        test_ignored();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
